// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the coalescing store buffer.
// The optional forwarding datapath is selected by STORE_BUFFER_FWD_EN.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef logic [31:0] data_t;

  localparam int SB_NB = $bits(data_t) / 8;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_t;

endpackage

// File: rtl/store_buffer_fwd_select.sv
// Per-lane youngest-entry byte select over age-ordered store buffer entries.
// Present only when STORE_BUFFER_FWD_EN is defined.
`ifdef STORE_BUFFER_FWD_EN
module sb_fwd_select
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int DATA_WIDTH = $bits(data_t)
) (
  input  logic [DEPTH-1:0]                 i_match,
  input  logic [DEPTH*(DATA_WIDTH/8)-1:0]  i_strb,
  input  logic [DEPTH*DATA_WIDTH-1:0]      i_data,
  output logic [DATA_WIDTH/8-1:0]          o_covered,
  output logic [DATA_WIDTH-1:0]            o_data
);

  localparam int NB = DATA_WIDTH / 8;

  // Slot 0 is the oldest entry, so later slots overwrite earlier ones per lane.
  always_comb begin
    o_covered = '0;
    o_data    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (i_match[k] && i_strb[k*NB + b]) begin
          o_covered[b]     = 1'b1;
          o_data[b*8 +: 8] = i_data[k*DATA_WIDTH + b*8 +: 8];
        end
      end
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// Coalescing in-order store buffer with load lookup and drain/fence handshake.
// Define STORE_BUFFER_FWD_EN to forward buffered bytes; otherwise overlapping loads stall.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = $bits(data_t),
  parameter int MERGE_EN_P = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           st_valid_i,
  output logic                           st_ready_o,
  input  logic [ADDR_WIDTH-1:0]          st_addr_i,
  input  logic [DATA_WIDTH-1:0]          st_data_i,
  input  logic [DATA_WIDTH/8-1:0]        st_strb_i,
  input  logic                           ld_valid_i,
  input  logic [ADDR_WIDTH-1:0]          ld_addr_i,
  input  logic [DATA_WIDTH/8-1:0]        ld_strb_i,
  output logic                           ld_fwd_hit_o,
  output logic [DATA_WIDTH-1:0]          ld_fwd_data_o,
  output logic                           ld_stall_o,
  output logic                           cache_req_o,
  output logic [ADDR_WIDTH-1:0]          cache_addr_o,
  output logic [DATA_WIDTH-1:0]          cache_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        cache_wstrb_o,
  input  logic                           cache_ready_i,
  input  logic                           drain_i,
  output logic                           drain_done_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o,
  output logic                           dbg_state_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int WA  = ADDR_WIDTH - OFF;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WA-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic [NB-1:0]         strb;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  sb_state_t        r_state;
  sb_state_t        w_state_next;
  logic             r_done;

  logic [WA-1:0]    w_st_word;
  logic [WA-1:0]    w_ld_word;
  logic [PW-1:0]    w_young;
  logic             w_deq;
  logic             w_merge_ok;
  logic             w_enq;
  logic             w_push;
  logic             w_merge;
  logic             w_done_set;
  logic [CW-1:0]    w_count_next;
  logic             w_unused_ok;

  assign w_st_word   = st_addr_i[ADDR_WIDTH-1:OFF];
  assign w_ld_word   = ld_addr_i[ADDR_WIDTH-1:OFF];
  assign w_unused_ok = ^{st_addr_i[OFF-1:0], ld_addr_i[OFF-1:0]};
  assign w_young     = r_tail - PW'(1);

  // Both ports use valid/ready: a transfer happens exactly in a cycle where
  // valid and ready are high together; valid never depends on ready.
  assign cache_req_o = r_valid[r_head];
  assign w_deq       = cache_req_o && cache_ready_i;

  // Never coalesce into the head that the cache is taking this cycle.
  assign w_merge_ok = (MERGE_EN_P != 0) && (r_count != '0) && (st_strb_i != '0) &&
                      (r_mem[w_young].addr == w_st_word) &&
                      !(w_deq && (w_young == r_head));

  assign st_ready_o   = (r_state == SB_RUN) && ((r_count < CW'(DEPTH)) || w_merge_ok);
  assign w_enq        = st_valid_i && st_ready_o;
  assign w_push       = w_enq && !w_merge_ok;
  assign w_merge      = w_enq && w_merge_ok;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_deq);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_mem[r_tail]   <= '{addr: w_st_word, data: st_data_i, strb: st_strb_i};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_merge) begin
        for (int b = 0; b < NB; b++) begin
          if (st_strb_i[b]) r_mem[w_young].data[b*8 +: 8] <= st_data_i[b*8 +: 8];
        end
        r_mem[w_young].strb <= r_mem[w_young].strb | st_strb_i;
      end
      r_count <= w_count_next;
    end
  end

  // The done pulse is registered so it lines up with count_o reading zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= SB_RUN;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_set;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      SB_RUN: begin
        if (drain_i) w_state_next = SB_DRAIN;
      end
      SB_DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next = SB_RUN;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = SB_RUN;
    endcase
  end

  assign drain_done_o  = r_done;
  assign count_o       = r_count;
  assign empty_o       = (r_count == '0);
  assign dbg_state_o   = (r_state == SB_DRAIN);
  assign cache_addr_o  = cache_req_o ? {r_mem[r_head].addr, {OFF{1'b0}}} : '0;
  assign cache_wdata_o = cache_req_o ? r_mem[r_head].data : '0;
  assign cache_wstrb_o = cache_req_o ? r_mem[r_head].strb : '0;

  // Entries presented oldest-first so the lookup can resolve age per lane.
  logic [DEPTH-1:0]    w_match;
  logic [DEPTH*NB-1:0] w_ostrb;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] w_idx;
    assign w_idx                = r_head + PW'(k);
    assign w_match[k]           = r_valid[w_idx] && (r_mem[w_idx].addr == w_ld_word);
    assign w_ostrb[k*NB +: NB]  = r_mem[w_idx].strb;
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH*DATA_WIDTH-1:0] w_odata;
  logic [NB-1:0]               w_sel_cov;
  logic [DATA_WIDTH-1:0]       w_sel_data;
  logic [NB-1:0]               w_cov;
  logic                        w_hit;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age_data
    logic [PW-1:0] w_didx;
    assign w_didx                             = r_head + PW'(k);
    assign w_odata[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_didx].data;
  end

  sb_fwd_select #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd_select (
    .i_match   (w_match),
    .i_strb    (w_ostrb),
    .i_data    (w_odata),
    .o_covered (w_sel_cov),
    .o_data    (w_sel_data)
  );

  assign w_cov        = w_sel_cov & ld_strb_i;
  assign w_hit        = ld_valid_i && (w_cov == ld_strb_i) && (w_cov != '0);
  assign ld_fwd_hit_o = w_hit;
  assign ld_stall_o   = ld_valid_i && (w_cov != '0) && (w_cov != ld_strb_i);

  always_comb begin
    ld_fwd_data_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_hit && w_cov[b]) ld_fwd_data_o[b*8 +: 8] = w_sel_data[b*8 +: 8];
    end
  end
`else
  logic w_overlap;

  always_comb begin
    w_overlap = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k] && ((w_ostrb[k*NB +: NB] & ld_strb_i) != '0)) w_overlap = 1'b1;
    end
  end

  assign ld_fwd_hit_o  = 1'b0;
  assign ld_fwd_data_o = '0;
  assign ld_stall_o    = ld_valid_i && w_overlap;
`endif

endmodule
